// File: rtl/shift_dispatch.sv
// shift_dispatch: issue stage that queues tagged shift ops, feeds an external barrel shifter and buffers its results
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   flush                 synchronous clear of queued, in-flight and buffered results
//   in_valid/in_ready     operation handshake carrying in_x, in_s, in_left, in_log, in_tag
//   sh_x/sh_s/sh_left/sh_log  operands to the shifter (FIFO head, zero when empty)
//   sh_z                  shifter result, valid one cycle after its operands
//   out_valid/out_ready   result handshake carrying out_z, out_tag
//   count                 operand FIFO occupancy
module shift_dispatch #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int RDEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_x,
    input  logic [4:0]               in_s,
    input  logic                     in_left,
    input  logic                     in_log,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [31:0]              sh_x,
    output logic [4:0]               sh_s,
    output logic                     sh_left,
    output logic                     sh_log,
    input  logic [31:0]              sh_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_z,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(RDEPTH);

    logic [31:0]      r_x    [DEPTH];
    logic [4:0]       r_s    [DEPTH];
    logic             r_left [DEPTH];
    logic             r_log  [DEPTH];
    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_count;
    logic             r_inflight;
    logic [TAG_W-1:0] r_iftag;
    logic [31:0]      r_rz [RDEPTH];
    logic [TAG_W-1:0] r_rt [RDEPTH];
    logic [RW-1:0]    r_rwp, r_rrp;
    logic [RW:0]      r_rcount;

    logic        w_push, w_has, w_rd, w_issue, w_cap;
    logic [RW+1:0] w_credit;

    assign w_has    = r_count != '0;
    assign in_ready = reset_n & ~flush & (r_count != (AW+1)'(DEPTH));
    assign w_push   = in_valid & in_ready;
    assign out_valid = r_rcount != '0;
    assign w_rd     = out_valid & out_ready;
    // A result leaving the buffer this cycle frees the slot the op issued now will need
    // two edges later, which is what sustains one op per cycle with only two entries.
    assign w_credit = (RW+2)'(r_rcount) + (RW+2)'(r_inflight) - (RW+2)'(w_rd);
    assign w_issue  = w_has & ~flush & (w_credit < (RW+2)'(RDEPTH));
    assign w_cap    = r_inflight & ~flush;

    assign sh_x    = w_has ? r_x[r_rp]    : '0;
    assign sh_s    = w_has ? r_s[r_rp]    : '0;
    assign sh_left = w_has ? r_left[r_rp] : 1'b0;
    assign sh_log  = w_has ? r_log[r_rp]  : 1'b0;
    assign out_z   = out_valid ? r_rz[r_rrp] : '0;
    assign out_tag = out_valid ? r_rt[r_rrp] : '0;
    assign count   = r_count;

    // Storage arrays need no reset: occupancy counters gate every read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_x[r_wp]    <= in_x;
            r_s[r_wp]    <= in_s;
            r_left[r_wp] <= in_left;
            r_log[r_wp]  <= in_log;
            r_tag[r_wp]  <= in_tag;
        end
        if (w_cap) begin
            r_rz[r_rwp] <= sh_z;
            r_rt[r_rwp] <= r_iftag;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_iftag    <= '0;
            r_rwp      <= '0;
            r_rrp      <= '0;
            r_rcount   <= '0;
        end else if (flush) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_rwp      <= '0;
            r_rrp      <= '0;
            r_rcount   <= '0;
        end else begin
            r_wp       <= r_wp + AW'(w_push);
            r_rp       <= r_rp + AW'(w_issue);
            r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_issue);
            r_inflight <= w_issue;
            r_iftag    <= r_tag[r_rp];
            r_rwp      <= r_rwp + RW'(w_cap);
            r_rrp      <= r_rrp + RW'(w_rd);
            r_rcount   <= r_rcount + (RW+1)'(w_cap) - (RW+1)'(w_rd);
        end
    end
endmodule

// File: tb/tb_shift_dispatch.sv
// tb_shift_dispatch: table-driven and sequence tests of shift_dispatch with a scoreboard and a behavioural shifter
module tb_shift_dispatch;
    localparam int DEPTH = 4, TAG_W = 4, RDEPTH = 2;

    logic clock = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, sh_left, sh_log;
    logic [31:0] in_x = 0, sh_x, sh_z, out_z;
    logic [4:0] in_s = 0, sh_s;
    logic in_left = 0, in_log = 0;
    logic [TAG_W-1:0] in_tag = 0, out_tag;
    logic [$clog2(DEPTH):0] count;

    shift_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .RDEPTH(RDEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_s(in_s),
        .in_left(in_left), .in_log(in_log), .in_tag(in_tag),
        .sh_x(sh_x), .sh_s(sh_s), .sh_left(sh_left), .sh_log(sh_log), .sh_z(sh_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_tag(out_tag),
        .count(count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s, input logic l, input logic lg);
        logic [31:0] r;
        if (l) r = x << s;
        else if (lg) r = x >> s;
        else r = $signed(x) >>> s;
        return r;
    endfunction

    // External shifter: operands registered every edge, never reset; garbage mode models an unknown power-up value.
    logic [31:0] m_x;
    logic [4:0] m_s;
    logic m_left, m_log, garbage = 0;
    always @(posedge clock) begin
        m_x <= sh_x; m_s <= sh_s; m_left <= sh_left; m_log <= sh_log;
    end
    assign sh_z = garbage ? 32'hDEAD_BEEF : ref_shift(m_x, m_s, m_left, m_log);

    typedef struct packed {logic [31:0] z; logic [TAG_W-1:0] tag;} res_t;
    res_t sb[$];
    logic [31:0] drv_exp = 0;
    int n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin : mon
        res_t e;
        if (!reset_n || flush) sb.delete();
        else begin
            if (out_valid && sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_result: got z=%h tag=%h, expected no result", out_z, out_tag);
            end else if (out_valid && out_ready) begin
                e = sb.pop_front();
                check("result_z", 64'(out_z), 64'(e.z));
                check("result_tag", 64'(out_tag), 64'(e.tag));
            end
            if (in_valid && in_ready) sb.push_back('{drv_exp, in_tag});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] x, input logic [4:0] s, input logic l, input logic lg,
                         input logic [TAG_W-1:0] t, input logic [31:0] e);
        in_x = x; in_s = s; in_left = l; in_log = lg; in_tag = t; drv_exp = e; in_valid = 1;
    endtask

    task automatic send(input logic [31:0] x, input logic [4:0] s, input logic l, input logic lg,
                        input logic [TAG_W-1:0] t, input logic [31:0] e);
        int w = 0;
        drive(x, s, l, lg, t, e);
        while (!in_ready && w < 50) begin tick(); w++; end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=0 after 50 cycles, expected 1");
        end
        tick();
        in_valid = 0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        out_ready = 1;
        while ((sb.size() != 0 || out_valid) && w < 100) begin tick(); w++; end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic fill6(input int base);
        logic [31:0] xv;
        for (int i = 0; i < 6; i++) begin
            xv = $urandom;
            send(xv, 5'(i * 5 + 1), i % 2 == 1, i % 3 == 0, TAG_W'(base + i),
                 ref_shift(xv, 5'(i * 5 + 1), i % 2 == 1, i % 3 == 0));
        end
        tick(2);
    endtask

    typedef struct {logic [31:0] x; logic [4:0] s; logic l, lg; logic [TAG_W-1:0] t; logic [31:0] z;} vec_t;
    vec_t tbl[10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h8000_0001, 5'd4,  1'b0, 1'b0, 4'h3, 32'hF800_0000};
        tbl[1] = '{32'h8000_0001, 5'd4,  1'b0, 1'b1, 4'h5, 32'h0800_0000};
        tbl[2] = '{32'h0000_0001, 5'd31, 1'b1, 1'b1, 4'h9, 32'h8000_0000};
        tbl[3] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 4'hA, 32'hDEAD_BEEF};
        tbl[4] = '{32'hF000_0000, 5'd31, 1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF};
        tbl[5] = '{32'h7FFF_FFFF, 5'd31, 1'b0, 1'b0, 4'h1, 32'h0000_0000};
        tbl[6] = '{32'h1234_5678, 5'd8,  1'b1, 1'b0, 4'h6, 32'h3456_7800};
        tbl[7] = '{32'h1234_5678, 5'd8,  1'b0, 1'b1, 4'h7, 32'h0012_3456};
        tbl[8] = '{32'hC000_0000, 5'd1,  1'b0, 1'b0, 4'h2, 32'hE000_0000};
        tbl[9] = '{32'hA5A5_A5A5, 5'd16, 1'b0, 1'b1, 4'hC, 32'h0000_A5A5};

        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_z", 64'(out_z), 64'd0);
        check("rst_sh_x", 64'(sh_x), 64'd0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1;
        #1 check("rel_in_ready", 64'(in_ready), 64'd1);
        tick();

        // single op, 3-cycle latency
        out_ready = 1;
        drive(32'h8000_0001, 5'd4, 1'b0, 1'b0, 4'h3, 32'hF800_0000);
        tick();
        in_valid = 0; in_x = $urandom; in_s = 5'($urandom); in_tag = 4'hE;
        check("k1_sh_x", 64'(sh_x), 64'h8000_0001);
        check("k1_sh_s", 64'(sh_s), 64'd4);
        check("k1_sh_ctl", 64'({sh_left, sh_log}), 64'd0);
        check("k1_out_valid", 64'(out_valid), 64'd0);
        tick();
        check("k2_out_valid", 64'(out_valid), 64'd0);
        check("k2_out_z", 64'(out_z), 64'd0);
        tick();
        check("k3_out_valid", 64'(out_valid), 64'd1);
        check("k3_out_z", 64'(out_z), 64'hF800_0000);
        check("k3_out_tag", 64'(out_tag), 64'd3);
        tick();
        check("k4_out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 10; i++) send(tbl[i].x, tbl[i].s, tbl[i].l, tbl[i].lg, tbl[i].t, tbl[i].z);
        drain("table_drain");

        // back-to-back 8 ops, continuous output
        for (int n = 0; n < 8; n++) begin
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            drive(32'h1, 5'(n), 1'b1, 1'b1, TAG_W'(n), 32'h1 << n);
            tick();
            check("b2b_out_valid", 64'(out_valid), n >= 2 ? 64'd1 : 64'd0);
        end
        in_valid = 0;
        for (int j = 0; j < 2; j++) begin
            tick();
            check("b2b_tail_valid", 64'(out_valid), 64'd1);
        end
        tick();
        check("b2b_end_valid", 64'(out_valid), 64'd0);

        // backpressure then full boundary (count 4,3,4)
        out_ready = 0;
        fill6(8);
        check("bp_count", 64'(count), 64'd4);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head_tag", 64'(out_tag), 64'd8);
        drive(32'h0000_0F00, 5'd4, 1'b0, 1'b1, 4'hE, 32'h0000_00F0);
        out_ready = 1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        tick();
        out_ready = 0;
        check("full_count_a", 64'(count), 64'd3);
        check("full_in_ready_b", 64'(in_ready), 64'd1);
        tick();
        in_valid = 0;
        check("full_count_b", 64'(count), 64'd4);
        drain("bp_drain");

        // flush with ops queued, in flight and buffered
        out_ready = 0;
        fill6(0);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("fl_pre_count", 64'(count), 64'd3);
        check("fl_pre_valid", 64'(out_valid), 64'd1);
        flush = 1;
        drive(32'h1234, 5'd1, 1'b1, 1'b1, 4'hD, 32'h2468);
        #1 check("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 0; in_valid = 0;
        check("fl_count", 64'(count), 64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("fl_quiet", 64'(out_valid), 64'd0);
        end
        drive(32'h0000_00F0, 5'd4, 1'b0, 1'b1, 4'h5, 32'h0000_000F);
        tick();
        in_valid = 0;
        tick();
        check("fl_new_k2", 64'(out_valid), 64'd0);
        tick();
        check("fl_new_valid", 64'(out_valid), 64'd1);
        check("fl_new_z", 64'(out_z), 64'h0000_000F);
        check("fl_new_tag", 64'(out_tag), 64'd5);
        tick();

        // asynchronous reset with every stage occupied
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(32'hF0F0_0000 + i, 5'(i), 1'b1, 1'b0, TAG_W'(i), ref_shift(32'hF0F0_0000 + i, 5'(i), 1'b1, 1'b0));
        drive(32'h55, 5'd1, 1'b1, 1'b1, 4'h9, 32'hAA);
        #2 reset_n = 0;
        #1;
        check("ar_in_ready", 64'(in_ready), 64'd0);
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_out_z", 64'(out_z), 64'd0);
        check("ar_out_tag", 64'(out_tag), 64'd0);
        check("ar_count", 64'(count), 64'd0);
        check("ar_sh", 64'({sh_x, sh_s, sh_left, sh_log}), 64'd0);
        in_valid = 0; garbage = 1;
        repeat (2) @(posedge clock);
        #3 reset_n = 1;
        out_ready = 1;
        for (int j = 0; j < 6; j++) begin
            tick();
            check("ar_garbage_ignored", 64'(out_valid), 64'd0);
        end
        garbage = 0;
        send(32'h8000_0000, 5'd31, 1'b0, 1'b0, 4'h4, 32'hFFFF_FFFF);
        drain("ar_final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
